i2c_master_core: RTL and testbench

Single-master I2C controller that executes byte-level bus operations: START, address, write, read and STOP. A host FSM or CPU bridge issues one-cycle command strobes and paces itself with `busy` and `ready`. The block drives SCL push-pull and SDA open-drain. An external pull-up on SDA is required.

---
 rtl/i2c_master_core_pkg.sv | 27 ++
 rtl/i2c_master_core_if.sv | 30 +++
 rtl/i2c_master_core_clk_div.sv | 29 ++
 rtl/i2c_master_core.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_master_core.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_master_core_pkg.sv
// Shared types for the I2C master core: FSM states,
// quarter-phase index, bit counter, quarter-period helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RSTART,
    ST_BIT,
    ST_ACK,
    ST_HOLD,
    ST_STOP
  } state_e;

  typedef logic [1:0] qphase_t;

  localparam int BIT_CNT_W = 4;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Quarter SCL period in system clocks, floor, at least 1.
  function automatic int calc_q(int clk_f, int i2c_f);
    int q;
    q = clk_f / (4 * i2c_f);
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/i2c_master_core_if.sv
// Host command/status bundle of the I2C master core.
// master = host side (drives strobes), slave = core side.
interface i2c_host_if;

  logic       start;
  logic       stop;
  logic       read;
  logic       write;
  logic [6:0] addr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       ack_received;
  logic       busy;
  logic       ready;

  modport master (
    output start, stop, read, write,
    output addr, tx_data,
    input  rx_data, ack_received,
    input  busy, ready
  );

  modport slave (
    input  start, stop, read, write,
    input  addr, tx_data,
    output rx_data, ack_received,
    output busy, ready
  );

endinterface

// File: rtl/i2c_master_core_clk_div.sv
// Quarter-period tick generator: tick every Q clocks.
// Ports: clk, rst (sync high), clr (sync restart), tick.
module i2c_clk_div #(
  parameter int Q = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (Q > 1) ? $clog2(Q) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == W'(Q - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_core.sv
// Single-master byte-level I2C controller.
// Ports: clk, rst (sync high), host (cmd/status), scl, sda (0/Z).
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  i2c_host_if.slave   host,
  output logic        scl,
  inout  wire         sda
);

  localparam int Q = calc_q(CLK_FREQ, I2C_FREQ);

  state_e   state_q, state_d;
  qphase_t  phase_q, phase_d;
  bit_cnt_t bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_mode_q, rx_mode_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;
  logic ready_q, ready_d;
  logic scl_q, scl_d;
  logic sda_low_q, sda_low_d;

  logic tick;
  logic div_clr;
  logic sda_in;

  // Divider idles at zero so each operation starts on a
  // full quarter period.
  assign div_clr = (state_q == ST_IDLE) ||
                   (state_q == ST_HOLD);

  i2c_clk_div #(.Q(Q)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  assign sda_in = sda;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_mode_d = rx_mode_q;
    ack_d     = ack_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host.start) begin
          state_d   = ST_START;
          phase_d   = '0;
          tx_sh_d   = {host.addr, host.read};
          rx_mode_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase_q == 2'd1) begin
            state_d   = ST_BIT;
            phase_d   = '0;
            bit_cnt_d = '0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_RSTART: begin
        if (tick) begin
          if (phase_q == 2'd1) begin
            state_d = ST_START;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      ST_BIT: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1)
            rx_sh_d = {rx_sh_q[6:0], sda_in};
          if (phase_q == 2'd3) begin
            // Shift in 1s so SDA stays released after the byte.
            tx_sh_d   = {tx_sh_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = ST_ACK;
              if (rx_mode_q) rx_data_d = rx_sh_q;
            end
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1 && !rx_mode_q)
            ack_d = !sda_in;
          if (phase_q == 2'd3)
            state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (host.stop) begin
          state_d = ST_STOP;
          phase_d = '0;
        end else if (host.start) begin
          state_d   = ST_RSTART;
          phase_d   = '0;
          tx_sh_d   = {host.addr, host.read};
          rx_mode_d = 1'b0;
        end else if (host.write) begin
          state_d   = ST_BIT;
          phase_d   = '0;
          bit_cnt_d = '0;
          tx_sh_d   = host.tx_data;
          rx_mode_d = 1'b0;
        end else if (host.read) begin
          state_d   = ST_BIT;
          phase_d   = '0;
          bit_cnt_d = '0;
          tx_sh_d   = 8'hFF;
          rx_mode_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (phase_q == 2'd2) begin
            state_d = ST_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they
  // line up with the state register.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    unique case (state_d)
      ST_IDLE: ;
      ST_START: sda_low_d = (phase_d == 2'd1);
      ST_RSTART: scl_d = (phase_d == 2'd1);
      ST_BIT: begin
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = !tx_sh_d[7];
      end
      ST_ACK: scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
      ST_HOLD: begin
        scl_d     = 1'b0;
        sda_low_d = sda_low_q;
      end
      ST_STOP: begin
        scl_d     = (phase_d != 2'd0);
        sda_low_d = (phase_d != 2'd2);
      end
      default: ;
    endcase
  end

  // busy spans accept edge through one cycle past IDLE;
  // ready needs a settled HOLD cycle.
  always_comb begin
    busy_d  = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    ready_d = (state_q == ST_HOLD) && (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_mode_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_mode_q <= rx_mode_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign host.rx_data      = rx_data_q;
  assign host.ack_received = ack_q;
  assign host.busy         = busy_q;
  assign host.ready        = ready_q;
  assign scl               = scl_q;
  assign sda = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: bus monitor + slave model,
// directed and random transfers against expected values.
module tb_i2c_master_core;

  localparam int CLK_F = 1_000_000;
  localparam int I2C_F = 100_000;
  localparam int QR = CLK_F / (4 * I2C_F);
  localparam int QP = (QR < 1) ? 1 : QR;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  wire  sda;
  logic slv_low = 1'b0;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_host_if hif ();

  i2c_master_core #(
    .CLK_FREQ (CLK_F),
    .I2C_FREQ (I2C_F)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (hif),
    .scl  (scl),
    .sda  (sda)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Bus-level monitor and slave model
  logic       ack_en   = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  int n_start = 0;
  int n_stop  = 0;
  int n_bytes = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_ack  = 1'b0;
  int bitn = 0;
  int byte_idx = 0;
  logic [7:0] sh = 8'h00;
  logic rw = 1'b0;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;

  always @(negedge clk) begin : mon
    logic s_scl, s_sda;
    s_scl = scl;
    s_sda = sda;
    if (rst) begin
      slv_low = 1'b0;
      bitn = 0;
    end else if (p_scl && s_scl && p_sda && !s_sda) begin
      n_start++;
      bitn = 0;
      byte_idx = 0;
      slv_low = 1'b0;
    end else if (p_scl && s_scl && !p_sda && s_sda) begin
      n_stop++;
      slv_low = 1'b0;
    end else if (!p_scl && s_scl) begin
      if (bitn < 8) begin
        sh = {sh[6:0], s_sda};
        bitn++;
      end else begin
        last_ack  = s_sda;
        last_byte = sh;
        n_bytes++;
        if (byte_idx == 0) rw = sh[0];
        byte_idx++;
        bitn = 0;
      end
    end else if (p_scl && !s_scl) begin
      if (bitn == 8)
        slv_low = ack_en && (byte_idx == 0 || !rw);
      else if (byte_idx == 1 && rw)
        slv_low = !slv_byte[7 - bitn];
      else
        slv_low = 1'b0;
    end
    p_scl = s_scl;
    p_sda = s_sda;
  end

  // Called at a negedge; returns at the negedge after the
  // accepting rising edge.
  task automatic strobe(logic s, logic p, logic r,
                        logic w, logic [6:0] a,
                        logic [7:0] d);
    hif.start   = s;
    hif.stop    = p;
    hif.read    = r;
    hif.write   = w;
    hif.addr    = a;
    hif.tx_data = d;
    @(posedge clk);
    @(negedge clk);
    hif.start = 1'b0;
    hif.stop  = 1'b0;
    hif.read  = 1'b0;
    hif.write = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (hif.ready === 1'b1) break;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (hif.busy === 1'b0) break;
    end
  endtask

  initial begin
    int n, s0, p0, nb;
    logic [6:0] a;
    logic [7:0] d;
    logic e;

    rst = 1'b1;
    hif.start = 1'b0;
    hif.stop = 1'b0;
    hif.read = 1'b0;
    hif.write = 1'b0;
    hif.addr = '0;
    hif.tx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda", 32'(sda), 1);
    chk("rst_busy", 32'(hif.busy), 0);
    chk("rst_ready", 32'(hif.ready), 0);
    chk("rst_ack", 32'(hif.ack_received), 0);
    chk("rst_rx", 32'(hif.rx_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // address write, nobody answers
    ack_en = 1'b0;
    s0 = n_start;
    strobe(1, 0, 0, 0, 7'h50, 8'h00);
    chk("busy_rise", 32'(hif.busy), 1);
    chk("ready_low", 32'(hif.ready), 0);
    wait_ready(n);
    chk("lat_start", n, 38 * QP + 1);
    chk("start_cond", n_start, s0 + 1);
    chk("addr_bits", 32'(last_byte), 32'h A0);
    chk("addr_slot9", 32'(last_ack), 1);
    chk("ack_none", 32'(hif.ack_received), 0);

    // data write with ACKing slave
    ack_en = 1'b1;
    strobe(0, 0, 0, 1, 7'h00, 8'hA5);
    chk("ready_fall", 32'(hif.ready), 0);
    wait_ready(n);
    chk("lat_write", n, 36 * QP + 1);
    chk("wr_bits", 32'(last_byte), 32'h A5);
    chk("wr_ack", 32'(hif.ack_received), 1);

    // random writes, random slave response
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      ack_en = e;
      strobe(0, 0, 0, 1, 7'h00, d);
      wait_ready(n);
      chk("rnd_wr_lat", n, 36 * QP + 1);
      chk("rnd_wr_bits", 32'(last_byte), 32'(d));
      chk("rnd_wr_ack", 32'(hif.ack_received), 32'(e));
    end

    // stop
    p0 = n_stop;
    strobe(0, 1, 0, 0, 7'h00, 8'h00);
    wait_idle(n);
    chk("lat_stop", n, 3 * QP + 1);
    chk("stop_cond", n_stop, p0 + 1);
    chk("stop_scl", 32'(scl), 1);
    chk("stop_sda", 32'(sda), 1);

    // read from 0x50, slave returns 0x3C
    ack_en = 1'b1;
    slv_byte = 8'h3C;
    strobe(1, 0, 1, 0, 7'h50, 8'h00);
    wait_ready(n);
    chk("rd_addr_bits", 32'(last_byte), 32'h A1);
    chk("rd_addr_ack", 32'(hif.ack_received), 1);
    strobe(0, 0, 1, 0, 7'h00, 8'h00);
    wait_ready(n);
    chk("lat_read", n, 36 * QP + 1);
    chk("rd_data", 32'(hif.rx_data), 32'h 3C);
    chk("rd_nack", 32'(last_ack), 1);
    chk("rd_ack_kept", 32'(hif.ack_received), 1);

    // repeated start into a random-address read
    a = 7'($urandom);
    d = 8'($urandom);
    slv_byte = d;
    s0 = n_start;
    p0 = n_stop;
    strobe(1, 0, 1, 0, a, 8'h00);
    wait_ready(n);
    chk("rs_start", n_start, s0 + 1);
    chk("rs_no_stop", n_stop, p0);
    chk("rs_addr", 32'(last_byte), 32'({a, 1'b1}));
    strobe(0, 0, 1, 0, 7'h00, 8'h00);
    wait_ready(n);
    chk("rs_rd_data", 32'(hif.rx_data), 32'(d));

    // stop wins over write
    nb = n_bytes;
    p0 = n_stop;
    strobe(0, 1, 0, 1, 7'h00, 8'h00);
    wait_idle(n);
    chk("sw_lat", n, 3 * QP + 1);
    chk("sw_stop", n_stop, p0 + 1);
    chk("sw_no_byte", n_bytes, nb);

    // reset in the middle of the address byte
    ack_en = 1'b0;
    strobe(1, 0, 0, 0, 7'h2A, 8'h00);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(hif.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", 32'(hif.busy), 0);
    chk("mr_ready", 32'(hif.ready), 0);
    chk("mr_scl", 32'(scl), 1);
    chk("mr_sda", 32'(sda), 1);
    @(negedge clk);

    // fresh transfer after the reset
    ack_en = 1'b1;
    strobe(1, 0, 0, 0, 7'h33, 8'h00);
    wait_ready(n);
    chk("post_lat", n, 38 * QP + 1);
    chk("post_addr", 32'(last_byte), 32'h 66);
    chk("post_ack", 32'(hif.ack_received), 1);
    strobe(0, 1, 0, 0, 7'h00, 8'h00);
    wait_idle(n);
    chk("post_idle", 32'(hif.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
